// File: rtl/fp_small_pkg.sv
// Shared constants and state type for the small floating-point add/sub datapath.
package fp_small_pkg;

   localparam int unsigned EXP_W  = 4;
   localparam int unsigned MANT_W = 5;

   localparam logic [EXP_W-1:0] EXP_MAX  = '1;
   localparam logic [EXP_W-1:0] EXP_ZERO = '0;
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } norm_state_t;

endpackage

// File: rtl/fp_normalize.sv
// Result normaliser: classifies the raw adder sum, then left-shifts one bit per cycle until the
// leading one reaches the significand MSB, with overflow/underflow/zero flagging.
module fp_normalize
   import fp_small_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W:0]   in_mant,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sign,
   output logic [EXP_W-1:0]  out_exp,
   output logic [MANT_W-1:0] out_mant,
   output logic              out_zero,
   output logic              out_ovf,
   output logic              out_unf
);

   norm_state_t       state;
   logic              res_sign;
   logic [EXP_W-1:0]  res_exp;
   logic [MANT_W-1:0] res_mant;
   logic              res_zero;
   logic              res_ovf;
   logic              res_unf;

   // Held low during reset so nothing is accepted until reset has been released.
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);

   assign out_sign = res_sign;
   assign out_exp  = res_exp;
   assign out_mant = res_mant;
   assign out_zero = res_zero;
   assign out_ovf  = res_ovf;
   assign out_unf  = res_unf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         res_sign <= 1'b0;
         res_exp  <= EXP_ZERO;
         res_mant <= '0;
         res_zero <= 1'b0;
         res_ovf  <= 1'b0;
         res_unf  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  res_sign <= in_sign;
                  res_exp  <= in_exp;
                  res_mant <= in_mant[MANT_W-1:0];
                  res_zero <= 1'b0;
                  res_ovf  <= 1'b0;
                  res_unf  <= 1'b0;
                  if (in_zero || (in_mant == '0)) begin
                     state    <= DONE;
                     res_zero <= 1'b1;
                     res_sign <= 1'b0;
                     res_exp  <= EXP_ZERO;
                     res_mant <= '0;
                  end else if (in_mant[MANT_W]) begin
                     state <= DONE;
                     if (in_exp == EXP_MAX) begin
                        res_ovf  <= 1'b1;
                        res_mant <= '1;
                     end else begin
                        // Carry out: drop the LSB and bump the exponent.
                        res_mant <= in_mant[MANT_W:1];
                        res_exp  <= in_exp + 1'b1;
                     end
                  end else if (in_mant[MANT_W-1]) begin
                     state <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (res_mant[MANT_W-1]) begin
                  state <= DONE;
               end else if (res_exp == EXP_ONE) begin
                  state    <= DONE;
                  res_unf  <= 1'b1;
                  res_zero <= 1'b1;
                  res_sign <= 1'b0;
                  res_exp  <= EXP_ZERO;
                  res_mant <= '0;
               end else begin
                  res_mant <= {res_mant[MANT_W-2:0], 1'b0};
                  res_exp  <= res_exp - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_normalize.sv
// Directed-vector bench for fp_normalize with hand-computed expected results.
module tb_fp_normalize;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_sign;
   logic [3:0] in_exp;
   logic [5:0] in_mant;
   logic       in_zero;
   logic       out_valid;
   logic       out_ready;
   logic       out_sign;
   logic [3:0] out_exp;
   logic [4:0] out_mant;
   logic       out_zero;
   logic       out_ovf;
   logic       out_unf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fp_normalize dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .in_zero   (in_zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_exp   (out_exp),
      .out_mant  (out_mant),
      .out_zero  (out_zero),
      .out_ovf   (out_ovf),
      .out_unf   (out_unf)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic check_result(input string tag, input logic es, input logic [3:0] ee,
                               input logic [4:0] em, input logic ez, input logic eo,
                               input logic eu);
      check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
      check_val({tag, ".sign"}, 32'(out_sign), 32'(es));
      check_val({tag, ".exp"}, 32'(out_exp), 32'(ee));
      check_val({tag, ".mant"}, 32'(out_mant), 32'(em));
      check_val({tag, ".zero"}, 32'(out_zero), 32'(ez));
      check_val({tag, ".ovf"}, 32'(out_ovf), 32'(eo));
      check_val({tag, ".unf"}, 32'(out_unf), 32'(eu));
   endtask

   // Launch one op; lat is the number of clock edges after the accept edge until out_valid.
   task automatic run_op(input string tag, input logic s, input logic [3:0] e,
                         input logic [5:0] m, input logic z, input int want_lat,
                         input int hold, input logic es, input logic [3:0] ee,
                         input logic [4:0] em, input logic ez, input logic eo, input logic eu);
      int lat;
      check_val({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      in_zero  = z;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sign  = 1'b0;
      in_exp   = 4'd0;
      in_mant  = 6'd0;
      in_zero  = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_val({tag, ".lat"}, 32'(lat), 32'(want_lat));
      check_result(tag, es, ee, em, ez, eo, eu);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_val({tag, ".hold_busy"}, 32'(in_ready), 32'd0);
         check_result({tag, ".hold"}, es, ee, em, ez, eo, eu);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_val({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
      check_val({tag, ".back_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 4'd0;
      in_mant   = 6'd0;
      in_zero   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_val("rst.in_ready", 32'(in_ready), 32'd1);
      check_val("rst.out_valid", 32'(out_valid), 32'd0);
      check_val("rst.data", {21'd0, out_sign, out_exp, out_mant}, 32'd0);
      check_val("rst.flags", {29'd0, out_zero, out_ovf, out_unf}, 32'd0);
      @(posedge clk);
      #1;

      //      tag      s     e      m           z     lat hold es   ee     em         ez eo eu
      run_op("norm",  1'b0, 4'd7,  6'b010110, 1'b0, 0, 0, 1'b0, 4'd7,  5'b10110, 0, 0, 0);
      run_op("carry", 1'b1, 4'd7,  6'b101101, 1'b0, 0, 0, 1'b1, 4'd8,  5'b10110, 0, 0, 0);
      run_op("shift", 1'b0, 4'd9,  6'b000011, 1'b0, 4, 0, 1'b0, 4'd6,  5'b11000, 0, 0, 0);
      run_op("unf",   1'b1, 4'd2,  6'b000001, 1'b0, 2, 0, 1'b0, 4'd0,  5'b00000, 1, 0, 1);
      run_op("ovf",   1'b0, 4'd15, 6'b100000, 1'b0, 0, 0, 1'b0, 4'd15, 5'b11111, 0, 1, 0);
      run_op("mzero", 1'b1, 4'd5,  6'b000000, 1'b0, 0, 0, 1'b0, 4'd0,  5'b00000, 1, 0, 0);
      run_op("zhold", 1'b1, 4'd6,  6'b011011, 1'b1, 0, 3, 1'b0, 4'd0,  5'b00000, 1, 0, 0);

      // Reset in the middle of a shift sequence must abort the op.
      in_valid = 1'b1;
      in_exp   = 4'd9;
      in_mant  = 6'b000011;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_mant  = 6'd0;
      in_exp   = 4'd0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_val("abort.valid_in_rst", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_val("abort.valid", 32'(out_valid), 32'd0);
      check_val("abort.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check_val("abort.no_result", 32'(out_valid), 32'd0);
      run_op("after", 1'b1, 4'd9, 6'b000011, 1'b0, 4, 0, 1'b1, 4'd6, 5'b11000, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
